// File: rtl/ob_ctlr.sv
// rtl/ob_ctlr.sv - result-bank to C2H AXI-Stream outbound controller
module ob_ctlr #(
    parameter int NUM_BANKS  = 8,
    parameter int BANK_WORDS = 512,
    parameter int ADDR_W     = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_BANKS-1:0] RamValid,
    output logic [NUM_BANKS-1:0] DataDone,
    output logic                 RdEn,
    output logic [ADDR_W-1:0]    RdAddr,
    input  logic [127:0]         RdData,
    output logic [63:0]          s_axis_c2h_tdata_0,
    output logic                 s_axis_c2h_tlast_0,
    output logic                 s_axis_c2h_tvalid_0,
    input  logic                 s_axis_c2h_tready_0,
    output logic [7:0]           s_axis_c2h_tkeep_0
);
    localparam int WIDX_W = $clog2(BANK_WORDS);
    localparam int PTR_W  = ADDR_W - WIDX_W;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [WIDX_W-1:0] widx;
    logic              rd_vld;
    logic [127:0]      buf_mem [2];
    logic              wr_sel;
    logic              rd_sel;
    logic [1:0]        cnt;
    logic              half;

    logic              out_free;
    logic              load;
    logic              push;
    logic              pop;
    logic [1:0]        cnt_nxt;
    logic              can_issue;
    logic              last_beat;
    logic              hs;
    logic [127:0]      src_word;

    assign s_axis_c2h_tkeep_0 = 8'hFF;

    // With the buffer empty, the arriving RAM word feeds the output register directly
    // so the first beat appears the cycle after RdData is valid.
    always_comb begin
        out_free  = !s_axis_c2h_tvalid_0 || s_axis_c2h_tready_0;
        hs        = s_axis_c2h_tvalid_0 && s_axis_c2h_tready_0;
        src_word  = (cnt != 2'd0) ? buf_mem[rd_sel] : RdData;
        load      = out_free && ((cnt != 2'd0) || rd_vld);
        push      = rd_vld;
        pop       = load && half;
        cnt_nxt   = cnt + 2'(push) - 2'(pop);
        can_issue = (3'(cnt_nxt) + 3'(RdEn)) < 3'd2;
        last_beat = (state == DRAIN) && pop && (cnt == 2'd1) && !rd_vld && !RdEn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            ptr                 <= '0;
            widx                <= '0;
            rd_vld              <= 1'b0;
            buf_mem[0]          <= '0;
            buf_mem[1]          <= '0;
            wr_sel              <= 1'b0;
            rd_sel              <= 1'b0;
            cnt                 <= 2'd0;
            half                <= 1'b0;
            DataDone            <= '0;
            RdEn                <= 1'b0;
            RdAddr              <= '0;
            s_axis_c2h_tdata_0  <= '0;
            s_axis_c2h_tlast_0  <= 1'b0;
            s_axis_c2h_tvalid_0 <= 1'b0;
        end else begin
            DataDone <= '0;
            rd_vld   <= RdEn;
            cnt      <= cnt_nxt;
            if (push) begin
                buf_mem[wr_sel] <= RdData;
                wr_sel          <= ~wr_sel;
            end
            if (pop) begin
                rd_sel <= ~rd_sel;
            end
            if (load) begin
                s_axis_c2h_tdata_0  <= half ? src_word[127:64] : src_word[63:0];
                s_axis_c2h_tlast_0  <= last_beat;
                s_axis_c2h_tvalid_0 <= 1'b1;
                half                <= ~half;
            end else if (hs) begin
                s_axis_c2h_tvalid_0 <= 1'b0;
                s_axis_c2h_tlast_0  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    RdEn <= 1'b0;
                    if (RamValid[ptr]) begin
                        RdEn   <= 1'b1;
                        RdAddr <= {ptr, {WIDX_W{1'b0}}};
                        widx   <= WIDX_W'(1);
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    if (can_issue) begin
                        RdEn   <= 1'b1;
                        RdAddr <= {ptr, widx};
                        widx   <= widx + WIDX_W'(1);
                        if (widx == WIDX_W'(BANK_WORDS - 1)) begin
                            state <= DRAIN;
                        end
                    end else begin
                        RdEn <= 1'b0;
                    end
                end
                DRAIN: begin
                    RdEn <= 1'b0;
                    if (last_beat) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Output register holds the tlast beat; release the bank on its handshake.
                    if (hs) begin
                        DataDone <= NUM_BANKS'(1) << ptr;
                        ptr      <= (ptr == PTR_W'(NUM_BANKS - 1)) ? '0 : ptr + PTR_W'(1);
                        widx     <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
